trig_event_fifo: RTL

Downstream neighbour of the trigger-decision block in the clk_adc domain. It watches the 16 trigger outputs and stores one timestamped record for every new trigger. Each record holds the output edge mask, the last-fired trigger number, the 56-bit clock counter and the 64-bit masked input pattern, in a DEPTH-entry FIFO. Records are read out as five 32-bit words through a valid/ack port toward the slow-control side.

---
 rtl/trig_event_fifo_if.sv | 22 ++
 rtl/trig_event_fifo.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/trig_event_fifo_if.sv
// Readout port of trig_event_fifo: one 32-bit record word at a time with valid/ack.
// The master side presents words; the slave side consumes them with rd_ack.
interface trig_event_fifo_if;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_ack;
  logic        rd_last;

  modport master (
    output rd_data,
    output rd_valid,
    output rd_last,
    input  rd_ack
  );

  modport slave (
    input  rd_data,
    input  rd_valid,
    input  rd_last,
    output rd_ack
  );
endinterface

// File: rtl/trig_event_fifo.sv
// Trigger event FIFO: captures one timestamped record per new trigger-output edge
// and reads each record out as five 32-bit words over a valid/ack port.
module trig_event_fifo #(
  parameter int DEPTH = 16,
  parameter int NOUT  = 16,
  parameter int NIN   = 64,
  parameter int TS_W  = 56
) (
  input  logic              clk_adc,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic [NOUT-1:0]   trig_out,
  input  logic [7:0]        trig_num,
  input  logic [TS_W-1:0]   timestamp,
  input  logic [NIN-1:0]    in_pattern,
  trig_event_fifo_if.master rd,
  output logic [6:0]        count,
  output logic              full,
  output logic [15:0]       overflow_cnt
);

  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [6:0] DEPTH_C = 7'(DEPTH);

  // Readout FSM states.
  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] PRESENT = 1'b1;

  typedef struct packed {
    logic [15:0] mask;
    logic [7:0]  seq;
    logic [7:0]  num;
    logic [55:0] ts;
    logic [63:0] pattern;
  } record_t;

  record_t         mem [DEPTH];
  record_t         head;
  logic [NOUT-1:0] trig_out_d;
  logic [NOUT-1:0] rise;
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [7:0]      seq;
  logic [0:0]      state;
  logic [2:0]      widx;
  logic [31:0]     rd_data_q;
  logic            rd_valid_q;
  logic            flush;
  logic            capture;
  logic            wr_en;
  logic            pop;
  logic [6:0]      count_nxt;

  // Word idx (0..4) of a stored record, in readout order.
  function automatic logic [31:0] word_of(input record_t r, input logic [2:0] idx);
    case (idx)
      3'd0:    word_of = {8'hA5, r.seq, r.mask};
      3'd1:    word_of = {r.num, r.ts[55:32]};
      3'd2:    word_of = r.ts[31:0];
      3'd3:    word_of = r.pattern[63:32];
      default: word_of = r.pattern[31:0];
    endcase
  endfunction

  assign flush   = reset | clear;
  assign rise    = trig_out & ~trig_out_d;
  assign capture = enable & (|rise) & ~flush;
  // The full test uses the registered (pre-edge) flag, so a same-edge pop never frees a slot.
  assign wr_en   = capture & ~full;
  assign pop     = (state == PRESENT) & rd.rd_ack & (widx == 3'd4) & ~flush;
  assign head    = mem[rptr];

  assign rd.rd_data  = rd_data_q;
  assign rd.rd_valid = rd_valid_q;
  assign rd.rd_last  = (state == PRESENT) && (widx == 3'd4);

  // Next occupancy: write and pop on the same edge cancel out.
  always_comb begin
    // NOTE: default assignment first so every path drives count_nxt and no latch is inferred.
    count_nxt = count;
    case ({wr_en, pop})
      2'b10:   count_nxt = count + 7'd1;
      2'b01:   count_nxt = count - 7'd1;
      default: count_nxt = count;
    endcase
  end

  // Record storage: all fields sampled on the capture edge.
  // NOTE: the storage array is deliberately not reset; pointers and count define valid slots.
  always_ff @(posedge clk_adc) begin
    if (wr_en) begin
      mem[wptr] <= {16'(rise), seq, trig_num, 56'(timestamp), 64'(in_pattern)};
    end
  end

  // Edge detect, pointers, counters and the readout FSM.
  // NOTE: non-blocking assignments throughout so every register sees pre-edge values.
  always_ff @(posedge clk_adc) begin
    if (flush) begin
      trig_out_d   <= '0;
      wptr         <= '0;
      rptr         <= '0;
      seq          <= '0;
      count        <= '0;
      full         <= 1'b0;
      overflow_cnt <= '0;
      state        <= IDLE;
      widx         <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
    end else begin
      trig_out_d <= trig_out;
      count      <= count_nxt;
      full       <= (count_nxt == DEPTH_C);

      if (capture) begin
        // Dropped records still consume a sequence number so the gap is visible downstream.
        seq <= seq + 8'd1;
        if (full) begin
          if (overflow_cnt != 16'hFFFF) overflow_cnt <= overflow_cnt + 16'd1;
        end else begin
          wptr <= wptr + AW'(1);
        end
      end

      if (state == IDLE) begin
        if (count != 7'd0) begin
          rd_data_q  <= word_of(head, 3'd0);
          rd_valid_q <= 1'b1;
          widx       <= 3'd0;
          state      <= PRESENT;
        end
      end else if (rd.rd_ack) begin
        if (widx == 3'd4) begin
          rptr       <= rptr + AW'(1);
          rd_valid_q <= 1'b0;
          state      <= IDLE;
        end else begin
          widx      <= widx + 3'd1;
          rd_data_q <= word_of(head, widx + 3'd1);
        end
      end
    end
  end

endmodule
